// File: rtl/fts_event_hold.sv
// Purpose: per-channel capture of fast-side words, published on slow_tick and held for HOLD_TICKS ticks.
// Latency: capture visible on in_ready next cycle; publish appears one cycle after the first tick following capture.
// Backpressure: in_ready low while a word is pending or held; requests then are dropped and flag overflow.
module fts_event_hold #(
  parameter int W          = 2,
  parameter int CH         = 2,
  parameter int HOLD_TICKS = 1
) (
  input  logic            fastclk,
  input  logic            rst,
  input  logic            slow_tick,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*W-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  output logic [CH*W-1:0] synced,
  output logic [CH-1:0]   out_valid,
  output logic [CH-1:0]   overflow,
  input  logic [CH-1:0]   ovf_clr
);

  localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_HOLD} state_t;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_buf;
    logic [W-1:0]    r_synced;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic            r_overflow;
    logic            w_load;
    logic            w_publish;
    logic            w_cnt_inc;
    logic            w_release;
    logic            w_drop;

    // Next-state and per-cycle actions; a tick seen in the capture cycle is deliberately ignored.
    always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_publish   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_release   = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid[c]) begin
            w_load      = 1'b1;
            w_state_nxt = S_PEND;
          end
        end
        S_PEND: begin
          w_drop = in_valid[c];
          if (slow_tick) begin
            w_publish   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          w_drop = in_valid[c];
          if (slow_tick) begin
            if (r_cnt == LAST) begin
              w_release   = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // State register.
    always_ff @(posedge fastclk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
    end

    // Capture buffer, published word, hold counter and valid flag.
    always_ff @(posedge fastclk or posedge rst) begin
      if (rst) begin
        r_buf       <= '0;
        r_synced    <= '0;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_load) r_buf <= in_data[c*W +: W];
        if (w_publish) begin
          r_synced    <= r_buf;
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
        end else if (w_cnt_inc) begin
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_release) r_out_valid <= 1'b0;
      end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge fastclk or posedge rst) begin
      if (rst)             r_overflow <= 1'b0;
      else if (w_drop)     r_overflow <= 1'b1;
      else if (ovf_clr[c]) r_overflow <= 1'b0;
    end

    assign in_ready[c]        = (r_state == S_IDLE);
    assign synced[c*W +: W]   = r_synced;
    assign out_valid[c]       = r_out_valid;
    assign overflow[c]        = r_overflow;
  end

endmodule

// File: tb/tb_fts_event_hold.sv
// Purpose: checks fts_event_hold (HOLD_TICKS=1 and 3 instances on shared stimulus) against a tick-count model.
// Latency: inputs driven after falling edge, outputs compared at the next falling edge.
// Backpressure: model treats any request while pending or holding as a drop.
module tb_fts_event_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [1:0] v;
  logic [3:0] d;
  logic [1:0] clr;

  logic [1:0] rdy1, ov1, ovf1;
  logic [3:0] syn1;
  logic [1:0] rdy3, ov3, ovf3;
  logic [3:0] syn3;

  int tests = 0;
  int fails = 0;

  // model state, index [instance][channel]; instance 0 holds 1 tick, instance 1 holds 3
  logic       pend [2][2];
  int         left [2][2];
  logic [1:0] bufm [2][2];
  logic [1:0] synm [2][2];
  logic       ovfm [2][2];

  always #5 clk = ~clk;

  fts_event_hold #(.W(2), .CH(2), .HOLD_TICKS(1)) dut1 (
    .fastclk(clk), .rst(rst), .slow_tick(tick), .in_valid(v), .in_data(d),
    .in_ready(rdy1), .synced(syn1), .out_valid(ov1), .overflow(ovf1), .ovf_clr(clr)
  );

  fts_event_hold #(.W(2), .CH(2), .HOLD_TICKS(3)) dut3 (
    .fastclk(clk), .rst(rst), .slow_tick(tick), .in_valid(v), .in_data(d),
    .in_ready(rdy3), .synced(syn3), .out_valid(ov3), .overflow(ovf3), .ovf_clr(clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) begin
        pend[m][c] = 1'b0; left[m][c] = 0; bufm[m][c] = '0;
        synm[m][c] = '0;   ovfm[m][c] = 1'b0;
      end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) begin
        int   h;
        logic drop;
        h    = (m == 0) ? 1 : 3;
        drop = 1'b0;
        if (!pend[m][c] && left[m][c] == 0) begin
          if (v[c]) begin
            pend[m][c] = 1'b1;
            bufm[m][c] = d[c*2 +: 2];
          end
        end else begin
          drop = v[c];
          if (pend[m][c]) begin
            if (tick) begin
              synm[m][c] = bufm[m][c];
              pend[m][c] = 1'b0;
              left[m][c] = h;
            end
          end else if (tick) begin
            left[m][c] = left[m][c] - 1;
          end
        end
        if (drop)        ovfm[m][c] = 1'b1;
        else if (clr[c]) ovfm[m][c] = 1'b0;
      end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) begin
        logic       g_rdy, g_ov, g_ovf;
        logic [1:0] g_syn;
        g_rdy = (m == 0) ? rdy1[c] : rdy3[c];
        g_ov  = (m == 0) ? ov1[c]  : ov3[c];
        g_ovf = (m == 0) ? ovf1[c] : ovf3[c];
        g_syn = (m == 0) ? syn1[c*2 +: 2] : syn3[c*2 +: 2];
        check($sformatf("h%0d_c%0d_in_ready", (m == 0) ? 1 : 3, c), 32'(g_rdy),
              32'(!pend[m][c] && left[m][c] == 0));
        check($sformatf("h%0d_c%0d_out_valid", (m == 0) ? 1 : 3, c), 32'(g_ov), 32'(left[m][c] > 0));
        check($sformatf("h%0d_c%0d_synced", (m == 0) ? 1 : 3, c), 32'(g_syn), 32'(synm[m][c]));
        check($sformatf("h%0d_c%0d_overflow", (m == 0) ? 1 : 3, c), 32'(g_ovf), 32'(ovfm[m][c]));
      end
  endtask

  // one clock cycle: drive at falling edge, advance model at rising edge, compare at next falling edge
  task automatic step(input logic t, input logic [1:0] vv, input logic [3:0] dd, input logic [1:0] cc);
    tick = t; v = vv; d = dd; clr = cc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    tick = 1'b0; v = '0; clr = '0; d = 4'($urandom);
    compare_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'h0, 2'b00);
  endtask

  int ov_cycles;

  initial begin
    rst = 1'b1; tick = 1'b0; v = '0; d = '0; clr = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("reset_in_ready", 32'(rdy1), 32'h3);
    check("reset_synced", 32'(syn3), 32'h0);
    rst = 1'b0;
    compare_all();

    // reset while ch0 is pending with 2'b11: buffer discarded, no later publish
    step(1'b0, 2'b01, 4'b0011, 2'b00);
    idle_n(1);
    #2 rst = 1'b1;
    #1 model_reset();
    check("rst_async_in_ready", 32'(rdy1), 32'h3);
    check("rst_async_out_valid", 32'(ov1), 32'h0);
    compare_all();
    @(negedge clk) rst = 1'b0;
    step(1'b1, 2'b00, 4'h0, 2'b00);
    check("rst_no_publish_valid", 32'(ov1), 32'h0);
    check("rst_no_publish_synced", 32'(syn1), 32'h0);

    // basic publish on ch0, ticks every 10 cycles
    step(1'b0, 2'b01, 4'b0011, 2'b00);
    check("basic_busy", 32'(rdy1[0]), 32'h0);
    idle_n(9);
    step(1'b1, 2'b00, 4'h0, 2'b00);
    check("basic_synced", 32'(syn1[1:0]), 32'h3);
    check("basic_valid", 32'(ov1[0]), 32'h1);
    check("basic_ch1_valid", 32'(ov1[1]), 32'h0);
    check("basic_ch1_synced", 32'(syn1[3:2]), 32'h0);
    idle_n(9);
    check("basic_still_valid", 32'(ov1[0]), 32'h1);
    step(1'b1, 2'b00, 4'h0, 2'b00);
    check("basic_drop_valid", 32'(ov1[0]), 32'h0);
    check("basic_ready_back", 32'(rdy1[0]), 32'h1);

    // capture on ch1 in the same cycle as a tick: publish waits for the next tick
    idle_n(9);
    step(1'b1, 2'b10, 4'b0100, 2'b00);
    check("simul_no_publish", 32'(ov1[1]), 32'h0);
    check("simul_busy", 32'(rdy1[1]), 32'h0);
    idle_n(9);
    step(1'b1, 2'b00, 4'h0, 2'b00);
    check("simul_publish_valid", 32'(ov1[1]), 32'h1);
    check("simul_publish_synced", 32'(syn1[3:2]), 32'h1);

    // overflow during the 3-tick hold; out_valid high for 30 cycles
    step(1'b0, 2'b01, 4'b0010, 2'b00);
    idle_n(9);
    step(1'b1, 2'b00, 4'h0, 2'b00);
    check("ovf_publish_valid", 32'(ov3[0]), 32'h1);
    ov_cycles = 1;
    for (int k = 1; k <= 35; k++) begin
      step(k % 10 == 0, (k == 1 || k == 5) ? 2'b01 : 2'b00, 4'b0001,
           (k == 3 || k == 5) ? 2'b01 : 2'b00);
      if (ov3[0]) ov_cycles++;
      if (k == 1) check("ovf_set", 32'(ovf3[0]), 32'h1);
      if (k == 3) check("ovf_cleared", 32'(ovf3[0]), 32'h0);
      if (k == 5) check("ovf_set_wins", 32'(ovf3[0]), 32'h1);
    end
    check("ovf_hold_cycles", 32'(ov_cycles), 32'd30);
    check("ovf_synced_kept", 32'(syn3[1:0]), 32'h2);

    // parallel capture on both channels with different words
    step(1'b0, 2'b11, 4'b1001, 2'b00);
    idle_n(4);
    step(1'b1, 2'b00, 4'h0, 2'b00);
    check("par_synced", 32'(syn1), 32'h9);
    check("par_valid", 32'(ov1), 32'h3);
    idle_n(4);
    step(1'b1, 2'b00, 4'h0, 2'b00);
    check("par_ready", 32'(rdy1), 32'h3);
    idle_n(2);
    step(1'b1, 2'b00, 4'h0, 2'b00);
    step(1'b1, 2'b00, 4'h0, 2'b00);

    // back-to-back ticks with a 1-tick hold
    step(1'b0, 2'b01, 4'b0001, 2'b00);
    step(1'b1, 2'b00, 4'h0, 2'b00);
    check("b2b_publish", 32'(ov1[0]), 32'h1);
    check("b2b_synced", 32'(syn1[1:0]), 32'h1);
    step(1'b1, 2'b00, 4'h0, 2'b00);
    check("b2b_idle", 32'(rdy1[0]), 32'h1);
    check("b2b_valid_low", 32'(ov1[0]), 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0,
           {1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0)},
           4'($urandom),
           {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fts_event_hold.md
# fts_event_hold

Multi-channel fast-to-slow transfer buffer. It runs entirely on `fastclk`; the slow domain appears only as a one-cycle `slow_tick` enable strobe. Each channel captures a word on a fast-side valid pulse and publishes it on the next `slow_tick`. It then holds the word, with `out_valid` high, for a programmable number of tick periods. This lets slow-rate consumers sample fast-domain events without losing them. It replaces the fixed-width, single-channel fast-to-slow synchroniser wherever slow logic is clock-enabled from `fastclk`.

## Interface
Parameters:
- `W`, default 2: data width per channel, ≥1.
- `CH`, default 2: number of independent channels, ≥1.
- `HOLD_TICKS`, default 1: number of `slow_tick` periods that `out_valid` stays high after publish, ≥1.

Ports:
- `fastclk` in, 1: the only clock; all state updates on its rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `slow_tick` in, 1: one-cycle strobe marking each slow-domain sampling point.
- `in_valid` in, CH: per-channel capture request, one bit per channel.
- `in_data` in, CH*W: channel c occupies bits [c*W +: W].
- `in_ready` out, CH: channel c is empty and will accept `in_valid`.
- `synced` out, CH*W: last published word per channel, same packing as `in_data`.
- `out_valid` out, CH: high while the channel's published word is inside its hold window.
- `overflow` out, CH: sticky flag, set when a request is dropped.
- `ovf_clr` in, CH: synchronous clear of `overflow`.

## Operation
- Each channel is independent. The per-channel FSM has three states: IDLE, PEND, HOLD.
- Each channel has these registers:
  - capture buffer, W bits;
  - `synced` word, W bits;
  - tick counter, $clog2(HOLD_TICKS+1) bits;
  - `overflow` bit.
- `in_ready[c]` = (state == IDLE). It is combinational from state only.
- IDLE:
  - `in_valid` = 1: load buffer from `in_data`, go to PEND.
  - `slow_tick` in the same cycle is ignored. Publish waits for the next tick.
- PEND:
  - `slow_tick` = 1: `synced` ← buffer, `out_valid` ← 1, counter ← 0, go to HOLD.
- HOLD:
  - each `slow_tick`: if counter == HOLD_TICKS-1, `out_valid` ← 0 and go to IDLE; else counter ← counter+1.
- Overflow:
  - `in_valid` = 1 while not IDLE: word dropped, buffer and `synced` unchanged, `overflow` ← 1.
  - `ovf_clr` = 1 clears `overflow`, except in a cycle where a drop also occurs: set wins.
- `synced` keeps its last published value after HOLD ends. It changes only on a publish.
- Reset mid-operation: every channel returns to IDLE immediately. Pending buffers are discarded with no publish.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready` = all 1;
  - `synced` = 0;
  - `out_valid` = 0;
  - `overflow` = 0;
  - counter = 0.
- Capture: `in_valid` accepted at edge t → `in_ready` low from t+1.
- Publish: first `slow_tick` sampled at edge u > t → `synced` and `out_valid` update at u+1 (one-cycle latency after the tick).
- `out_valid` stays high from the publish tick edge through the edge of the HOLD_TICKS-th subsequent tick.
  - With periodic ticks of period P cycles, this is exactly HOLD_TICKS*P cycles.
- `in_ready` returns high the cycle after the final hold tick. Minimum spacing between accepted words is HOLD_TICKS+1 ticks.
- Back-to-back `slow_tick` on consecutive cycles is legal. Each pulse counts as one tick.
- `in_data` is sampled only in the accept cycle. It need not be held afterwards.

## Test plan
- Reset behaviour: assert `rst` mid-simulation with ch0 in PEND holding 2'b11.
  - All outputs go to their reset values asynchronously.
  - After release, the next tick does not publish.
- Basic publish: CH=2, W=2, HOLD_TICKS=1, tick every 10 cycles. Pulse `in_valid[0]` with 2'b11 on a falling-edge-aligned cycle.
  - `synced[1:0]` = 2'b11 and `out_valid[0]` = 1 one cycle after the next tick.
  - `out_valid[0]` drops one cycle after the following tick.
  - Channel 1 is untouched.
- Simultaneous capture and tick: `in_valid[1]` = 1 with 2'b01 in the same cycle as `slow_tick`.
  - No publish on that tick.
  - Publish occurs on the next tick, 10 cycles later.
- Overflow: HOLD_TICKS=3. Send a second word to ch0 while in HOLD.
  - `overflow[0]` = 1.
  - `synced` keeps the first word.
  - `out_valid[0]` is high for 30 cycles.
  - `ovf_clr[0]` then clears the flag.
  - `ovf_clr[0]` asserted in a cycle with a new drop leaves the flag at 1.
- Parallel channels: both channels captured in the same cycle with different words.
  - Both publish on the same tick, with independent values.
  - Both release `in_ready` together.
- Back-to-back ticks: ticks on cycles n and n+1 with HOLD_TICKS=1.
  - Publish at n+1.
  - IDLE at n+2.
